// File: rtl/bc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bc_pkg
// Description : Shared datapath constants for the buffer/control slice.
// Revision    : 1.0 - initial release
// ============================================================================
package bc_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int BR_DEPTH_DEF = 4;

    // Control word bit that the control unit routes to the buffer load strobe.
    localparam int C7_LOAD      = 7;

endpackage : bc_pkg
`default_nettype wire

// File: rtl/br_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : br_fifo_mem
// Description : DEPTH x DATA_W register array, sync write / async read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module br_fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : br_fifo_mem
`default_nettype wire

// File: rtl/br_fifo.sv
`default_nettype none
// ============================================================================
// Module      : br_fifo
// Description : First-word-fall-through operand queue between MBR and ALU/ACC.
// Revision    : 1.0 - initial release
// ============================================================================
module br_fifo
    import bc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = BR_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DATA_W-1:0]      MBR_in,
    input  logic                   pop,
    input  logic                   flush,
    output logic [DATA_W-1:0]      BR_out,
    output logic                   BR_valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic                   udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rp_q, rp_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == CW'(DEPTH));
    // A pop frees a slot in the same edge, so a full queue still accepts load+pop.
    assign w_push  = load && (!w_full || pop);
    assign w_pop   = pop && !w_empty;
    assign w_we    = w_push && !flush;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (w_push) begin
                wp_d = wp_q + 1'b1;
            end
            if (w_pop) begin
                rp_d = rp_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + 1'b1;
            end else if (w_pop && !w_push) begin
                count_d = count_q - 1'b1;
            end
            if (load && w_full && !pop) begin
                ovf_d = 1'b1;
            end
            if (pop && w_empty) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    br_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (wp_q),
        .wdata (MBR_in),
        .raddr (rp_q),
        .rdata (w_rdata)
    );

    assign BR_out   = w_empty ? '0 : w_rdata;
    assign BR_valid = !w_empty;
    assign full     = w_full;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule : br_fifo
`default_nettype wire

// File: tb/tb_br_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_fifo
// Description : Directed plus random bench for br_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_br_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              load;
    logic [DATA_W-1:0] MBR_in;
    logic              pop;
    logic              flush;
    logic [DATA_W-1:0] BR_out;
    logic              BR_valid;
    logic              full;
    logic [2:0]        count;
    logic              ovf;
    logic              udf;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] q [$];
    bit                m_ovf;
    bit                m_udf;

    br_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .MBR_in   (MBR_in),
        .pop      (pop),
        .flush    (flush),
        .BR_out   (BR_out),
        .BR_valid (BR_valid),
        .full     (full),
        .count    (count),
        .ovf      (ovf),
        .udf      (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] exp_out;
        exp_out = (q.size() != 0) ? q[0] : '0;
        check({tag, ".BR_out"},   32'(BR_out),   32'(exp_out));
        check({tag, ".BR_valid"}, 32'(BR_valid), 32'(q.size() != 0));
        check({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
        check({tag, ".count"},    32'(count),    32'(q.size()));
        check({tag, ".ovf"},      32'(ovf),      32'(m_ovf));
        check({tag, ".udf"},      32'(udf),      32'(m_udf));
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // One clock of stimulus: drive at negedge, model the edge, check at next negedge.
    task automatic step(input string tag, input logic l, input logic [DATA_W-1:0] d,
                        input logic p, input logic f);
        int sz;
        load   = l;
        MBR_in = d;
        pop    = p;
        flush  = f;
        sz     = q.size();
        @(posedge clk);
        if (f) begin
            model_reset();
        end else begin
            if (p && sz == 0)                m_udf = 1'b1;
            if (l && sz == DEPTH && !p)      m_ovf = 1'b1;
            if (p && sz > 0)                 void'(q.pop_front());
            if (l && (sz < DEPTH || p))      q.push_back(d);
        end
        @(negedge clk);
        load  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        MBR_in = '0;
        pop    = 1'b0;
        flush  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        step("load_a5", 1'b1, 16'hA5A5, 1'b0, 1'b0);
        check("load_a5.literal", 32'(BR_out), 32'h0000A5A5);
        step("pop_a5", 1'b0, 16'h0, 1'b1, 1'b0);

        for (int i = 1; i <= 5; i++) begin
            step("fill", 1'b1, DATA_W'(i), 1'b0, 1'b0);
        end
        check("fill.ovf_literal", 32'(ovf), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step("drain", 1'b0, 16'h0, 1'b1, 1'b0);
        end

        step("flush_clr", 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step("refill", 1'b1, DATA_W'(i), 1'b0, 1'b0);
        end
        step("full_lp", 1'b1, 16'h0009, 1'b1, 1'b0);
        check("full_lp.head_literal", 32'(BR_out), 32'h00000002);
        for (int i = 0; i < 4; i++) begin
            step("full_lp_drain", 1'b0, 16'h0, 1'b1, 1'b0);
        end

        step("empty_lp", 1'b1, 16'h00FF, 1'b1, 1'b0);
        check("empty_lp.head_literal", 32'(BR_out), 32'h000000FF);
        step("empty_lp_pop", 1'b0, 16'h0, 1'b1, 1'b0);
        step("udf_again", 1'b0, 16'h0, 1'b1, 1'b0);

        step("wrap_pre", 1'b1, 16'h1000, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step("wrap", 1'b1, 16'h1000 + DATA_W'(i), 1'b1, 1'b0);
        end

        for (int i = 0; i < 3; i++) begin
            step("pre_flush", 1'b1, 16'h2000 + DATA_W'(i), 1'b0, 1'b0);
        end
        step("flush_load", 1'b1, 16'h3333, 1'b0, 1'b1);
        step("post_flush_load", 1'b1, 16'h4444, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 16'hFFFF)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
        end

        for (int i = 0; i < 3; i++) begin
            step("burst", 1'b1, 16'h5000 + DATA_W'(i), 1'b0, 1'b0);
        end
        load   = 1'b1;
        MBR_in = 16'h6666;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_all("rst_hold");
        rst  = 1'b0;
        load = 1'b0;
        step("after_rst", 1'b1, 16'h7777, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_br_fifo
`default_nettype wire
